// File: rtl/jpeg_rx_pkg.sv
// Shared constants, state encodings and helpers for the UART JPEG receive path.
package jpeg_rx_pkg;

    localparam logic [7:0]  MARKER_FF = 8'hFF;
    localparam logic [7:0]  SOI_LO    = 8'hD8;
    localparam logic [7:0]  EOI_LO    = 8'hD9;
    localparam logic [23:0] CNT_MAX   = 24'hFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        HUNT,
        HUNT_FF,
        IMG,
        IMG_FF
    } frm_state_t;

    // Byte counter that sticks at all-ones instead of wrapping.
    function automatic logic [23:0] sat_inc(input logic [23:0] v);
        return (v == CNT_MAX) ? v : v + 24'd1;
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: two-flop synchronizer, mid-bit sampling FSM,
// one-cycle byte strobe and one-cycle frame-error pulse.
module uart_rx_byte
    import jpeg_rx_pkg::*;
#(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_stb,
    output logic       o_frame_error
);

    localparam int BIT_CYC     = CLK_FRE / BAUD_RATE;
    localparam int CNT_W       = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
    localparam int SYNC_STAGES = 2;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(BIT_CYC - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rxs;
    logic                   r_rxs_prev;

    rx_state_t        r_state,   w_state_next;
    logic [CNT_W-1:0] r_cyc_cnt, w_cyc_next;
    logic [2:0]       r_bit_cnt, w_bit_next;
    logic [7:0]       r_shift,   w_shift_next;
    logic             r_byte_stb, w_stb_next;
    logic             r_frame_error, w_ferr_next;

    // Synchronizer chain idles high so reset never looks like a start edge.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (rst) r_sync[gi] <= 1'b1;
                    else     r_sync[gi] <= i_uart_rx;
                end
            end else begin : g_rest
                always_ff @(posedge clk) begin
                    if (rst) r_sync[gi] <= 1'b1;
                    else     r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    assign w_rxs = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rxs_prev    <= 1'b1;
            r_state       <= IDLE;
            r_cyc_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_byte_stb    <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rxs_prev    <= w_rxs;
            r_state       <= w_state_next;
            r_cyc_cnt     <= w_cyc_next;
            r_bit_cnt     <= w_bit_next;
            r_shift       <= w_shift_next;
            r_byte_stb    <= w_stb_next;
            r_frame_error <= w_ferr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cyc_next   = r_cyc_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_stb_next   = 1'b0;
        w_ferr_next  = 1'b0;
        case (r_state)
            IDLE: begin
                w_cyc_next = '0;
                w_bit_next = '0;
                if (r_rxs_prev && !w_rxs) w_state_next = START;
            end
            START: begin
                // Re-check the line half a bit in to reject short glitches.
                if (r_cyc_cnt == HALF_LAST) begin
                    w_cyc_next   = '0;
                    w_state_next = w_rxs ? IDLE : DATA;
                end else begin
                    w_cyc_next = r_cyc_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cyc_cnt == FULL_LAST) begin
                    w_cyc_next   = '0;
                    w_shift_next = {w_rxs, r_shift[7:1]};
                    w_bit_next   = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_next = STOP;
                end else begin
                    w_cyc_next = r_cyc_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cyc_cnt == FULL_LAST) begin
                    w_cyc_next = '0;
                    if (w_rxs) begin
                        w_stb_next   = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = WAIT_HIGH;
                    end
                end else begin
                    w_cyc_next = r_cyc_cnt + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (w_rxs) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign o_byte        = r_shift;
    assign o_byte_stb    = r_byte_stb;
    assign o_frame_error = r_frame_error;

endmodule

// File: rtl/uart_jpeg_rx.sv
// UART JPEG receiver: recovers bytes from the serial line and forwards
// everything from SOI (FF D8) through EOI (FF D9) with a last flag on D9.
module uart_jpeg_rx
    import jpeg_rx_pkg::*;
#(
    parameter int CLK_FRE   = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic [7:0]  recv_data,
    output logic        recv_data_vaild,
    output logic        recv_data_last,
    output logic [23:0] recv_byte_cnt,
    output logic        jpeg_active,
    output logic        frame_error
);

    logic [7:0] w_byte;
    logic       w_byte_stb;
    logic       w_frame_error;

    uart_rx_byte #(
        .CLK_FRE   (CLK_FRE),
        .BAUD_RATE (BAUD_RATE)
    ) u_rx (
        .clk           (clk),
        .rst           (rst),
        .i_uart_rx     (uart_rx),
        .o_byte        (w_byte),
        .o_byte_stb    (w_byte_stb),
        .o_frame_error (w_frame_error)
    );

    frm_state_t  r_frm_state, w_frm_next;
    logic [7:0]  r_data,      w_data_next;
    logic        r_valid,     w_valid_next;
    logic        r_last,      w_last_next;
    logic [23:0] r_cnt,       w_cnt_next;
    logic        r_active,    w_active_next;
    logic        r_soi_pend,  w_pend_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frm_state <= HUNT;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_active    <= 1'b0;
            r_soi_pend  <= 1'b0;
        end else begin
            r_frm_state <= w_frm_next;
            r_data      <= w_data_next;
            r_valid     <= w_valid_next;
            r_last      <= w_last_next;
            r_cnt       <= w_cnt_next;
            r_active    <= w_active_next;
            r_soi_pend  <= w_pend_next;
        end
    end

    always_comb begin
        w_frm_next    = r_frm_state;
        w_data_next   = r_data;
        w_valid_next  = 1'b0;
        w_last_next   = 1'b0;
        w_cnt_next    = r_cnt;
        w_active_next = r_active;
        w_pend_next   = 1'b0;

        // Image ends the cycle after its D9 has been presented.
        if (r_last) w_active_next = 1'b0;

        // Second half of the SOI replay; strobes are far apart so this is free.
        if (r_soi_pend) begin
            w_data_next  = SOI_LO;
            w_valid_next = 1'b1;
            w_cnt_next   = sat_inc(r_cnt);
        end

        if (w_frame_error) begin
            if (r_frm_state == IMG || r_frm_state == IMG_FF) begin
                w_frm_next    = HUNT;
                w_active_next = 1'b0;
            end
        end else if (w_byte_stb) begin
            case (r_frm_state)
                HUNT: begin
                    if (w_byte == MARKER_FF) w_frm_next = HUNT_FF;
                end
                HUNT_FF: begin
                    if (w_byte == SOI_LO) begin
                        w_frm_next    = IMG;
                        w_active_next = 1'b1;
                        w_data_next   = MARKER_FF;
                        w_valid_next  = 1'b1;
                        w_cnt_next    = 24'd1;
                        w_pend_next   = 1'b1;
                    end else if (w_byte != MARKER_FF) begin
                        w_frm_next = HUNT;
                    end
                end
                IMG: begin
                    w_data_next  = w_byte;
                    w_valid_next = 1'b1;
                    w_cnt_next   = sat_inc(r_cnt);
                    if (w_byte == MARKER_FF) w_frm_next = IMG_FF;
                end
                IMG_FF: begin
                    w_data_next  = w_byte;
                    w_valid_next = 1'b1;
                    w_cnt_next   = sat_inc(r_cnt);
                    if (w_byte == EOI_LO) begin
                        w_last_next = 1'b1;
                        w_frm_next  = HUNT;
                    end else if (w_byte != MARKER_FF) begin
                        w_frm_next = IMG;
                    end
                end
                default: w_frm_next = HUNT;
            endcase
        end
    end

    assign recv_data       = r_data;
    assign recv_data_vaild = r_valid;
    assign recv_data_last  = r_last;
    assign recv_byte_cnt   = r_cnt;
    assign jpeg_active     = r_active;
    assign frame_error     = w_frame_error;

endmodule

// File: tb/tb_uart_jpeg_rx.sv
// Directed bench: serial bytes from a vector table, framed output checked per byte,
// plus glitch and mid-image reset sequences.
module tb_uart_jpeg_rx;

    localparam int CLK_FRE   = 2_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int BIT_CYC   = CLK_FRE / BAUD_RATE;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic [7:0]  recv_data;
    logic        recv_data_vaild;
    logic        recv_data_last;
    logic [23:0] recv_byte_cnt;
    logic        jpeg_active;
    logic        frame_error;

    uart_jpeg_rx #(
        .CLK_FRE   (CLK_FRE),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .uart_rx         (uart_rx),
        .recv_data       (recv_data),
        .recv_data_vaild (recv_data_vaild),
        .recv_data_last  (recv_data_last),
        .recv_byte_cnt   (recv_byte_cnt),
        .jpeg_active     (jpeg_active),
        .frame_error     (frame_error)
    );

    always #5 clk = ~clk;

    // Monitor: running totals, only ever written here.
    int         tot_emit = 0;
    int         tot_last = 0;
    int         tot_ferr = 0;
    int         tot_istb = 0;
    logic [7:0] ibyte_seen = 8'h00;
    logic       act_at_last = 1'b0;
    logic [7:0] emit_q[$];

    always @(negedge clk) begin
        if (recv_data_vaild) begin
            tot_emit++;
            emit_q.push_back(recv_data);
        end
        if (recv_data_last) begin
            tot_last++;
            act_at_last = jpeg_active;
        end
        if (frame_error) tot_ferr++;
        if (dut.u_rx.o_byte_stb) begin
            tot_istb++;
            ibyte_seen = dut.u_rx.o_byte;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic line_hold(input logic v, input int cyc);
        uart_rx = v;
        repeat (cyc) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        line_hold(1'b0, BIT_CYC);
        for (int i = 0; i < 8; i++) line_hold(d[i], BIT_CYC);
        line_hold(stop_ok, BIT_CYC);
        line_hold(1'b1, 2 * BIT_CYC);
    endtask

    typedef struct {
        logic [7:0]  tx;
        bit          stop_ok;
        int          exp_n;
        logic [7:0]  exp_data;
        bit          exp_last;
        logic [23:0] exp_cnt;
        bit          exp_active;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] tx, input bit stop_ok, input int n,
                                input logic [7:0] d, input bit last, input logic [23:0] cnt,
                                input bit act);
        vec_t v;
        v.tx = tx; v.stop_ok = stop_ok; v.exp_n = n; v.exp_data = d;
        v.exp_last = last; v.exp_cnt = cnt; v.exp_active = act;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        int b_emit, b_last, b_ferr, b_istb, b_q;
        vec_t v;

        // 0x55 alone; then image 1; junk + image 2; nested SOI; aborted image.
        vecs.push_back(mk(8'h55, 1, 0, 8'h00, 0, 24'd0, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 8'h00, 0, 24'd0, 0));
        vecs.push_back(mk(8'hD8, 1, 2, 8'hD8, 0, 24'd2, 1));
        vecs.push_back(mk(8'h12, 1, 1, 8'h12, 0, 24'd3, 1));
        vecs.push_back(mk(8'h34, 1, 1, 8'h34, 0, 24'd4, 1));
        vecs.push_back(mk(8'hFF, 1, 1, 8'hFF, 0, 24'd5, 1));
        vecs.push_back(mk(8'h00, 1, 1, 8'h00, 0, 24'd6, 1));
        vecs.push_back(mk(8'hFF, 1, 1, 8'hFF, 0, 24'd7, 1));
        vecs.push_back(mk(8'hD9, 1, 1, 8'hD9, 1, 24'd8, 0));
        vecs.push_back(mk(8'h00, 1, 0, 8'h00, 0, 24'd8, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 8'h00, 0, 24'd8, 0));
        vecs.push_back(mk(8'h41, 1, 0, 8'h00, 0, 24'd8, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 8'h00, 0, 24'd8, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 8'h00, 0, 24'd8, 0));
        vecs.push_back(mk(8'hD8, 1, 2, 8'hD8, 0, 24'd2, 1));
        vecs.push_back(mk(8'hAA, 1, 1, 8'hAA, 0, 24'd3, 1));
        vecs.push_back(mk(8'hFF, 1, 1, 8'hFF, 0, 24'd4, 1));
        vecs.push_back(mk(8'hD9, 1, 1, 8'hD9, 1, 24'd5, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 8'h00, 0, 24'd5, 0));
        vecs.push_back(mk(8'hD8, 1, 2, 8'hD8, 0, 24'd2, 1));
        vecs.push_back(mk(8'hFF, 1, 1, 8'hFF, 0, 24'd3, 1));
        vecs.push_back(mk(8'hD8, 1, 1, 8'hD8, 0, 24'd4, 1));
        vecs.push_back(mk(8'hFF, 1, 1, 8'hFF, 0, 24'd5, 1));
        vecs.push_back(mk(8'hD9, 1, 1, 8'hD9, 1, 24'd6, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 8'h00, 0, 24'd6, 0));
        vecs.push_back(mk(8'hD8, 1, 2, 8'hD8, 0, 24'd2, 1));
        vecs.push_back(mk(8'h11, 1, 1, 8'h11, 0, 24'd3, 1));
        vecs.push_back(mk(8'h22, 0, 0, 8'h00, 0, 24'd3, 0));
        vecs.push_back(mk(8'hFF, 1, 0, 8'h00, 0, 24'd3, 0));
        vecs.push_back(mk(8'hD9, 1, 0, 8'h00, 0, 24'd3, 0));

        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("reset data",   {24'd0, recv_data}, 32'd0);
        chk("reset valid",  {31'd0, recv_data_vaild}, 32'd0);
        chk("reset last",   {31'd0, recv_data_last}, 32'd0);
        chk("reset cnt",    {8'd0, recv_byte_cnt}, 32'd0);
        chk("reset active", {31'd0, jpeg_active}, 32'd0);
        chk("reset ferr",   {31'd0, frame_error}, 32'd0);
        rst = 1'b0;
        repeat (2 * BIT_CYC) @(posedge clk);

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            b_emit = tot_emit; b_last = tot_last; b_ferr = tot_ferr;
            b_istb = tot_istb; b_q = emit_q.size();
            send_byte(v.tx, v.stop_ok);
            @(negedge clk);
            $display("vec %0d tx=%02h stop=%0d emitted=%0d cnt=%0d active=%0b",
                     k, v.tx, v.stop_ok, tot_emit - b_emit, recv_byte_cnt, jpeg_active);
            chk($sformatf("v%0d istb", k), tot_istb - b_istb, v.stop_ok ? 1 : 0);
            if (v.stop_ok) chk($sformatf("v%0d ibyte", k), {24'd0, ibyte_seen}, {24'd0, v.tx});
            chk($sformatf("v%0d nemit", k), tot_emit - b_emit, v.exp_n);
            if (v.exp_n > 0)
                chk($sformatf("v%0d data", k), {24'd0, emit_q[emit_q.size() - 1]}, {24'd0, v.exp_data});
            if (v.exp_n == 2)
                chk($sformatf("v%0d soi ff", k), {24'd0, emit_q[b_q]}, 32'h0000_00FF);
            chk($sformatf("v%0d last", k), tot_last - b_last, v.exp_last ? 1 : 0);
            if (v.exp_last) chk($sformatf("v%0d active at last", k), {31'd0, act_at_last}, 32'd1);
            chk($sformatf("v%0d cnt", k), {8'd0, recv_byte_cnt}, {8'd0, v.exp_cnt});
            chk($sformatf("v%0d active", k), {31'd0, jpeg_active}, v.exp_active ? 1 : 0);
            chk($sformatf("v%0d ferr", k), tot_ferr - b_ferr, v.stop_ok ? 0 : 1);
        end

        // Short low glitch shorter than half a bit: nothing decoded.
        b_istb = tot_istb; b_ferr = tot_ferr;
        line_hold(1'b0, BIT_CYC / 2 - 4);
        line_hold(1'b1, 3 * BIT_CYC);
        @(negedge clk);
        $display("glitch low %0d cycles: strobes=%0d ferr=%0d", BIT_CYC / 2 - 4,
                 tot_istb - b_istb, tot_ferr - b_ferr);
        chk("glitch istb", tot_istb - b_istb, 0);
        chk("glitch ferr", tot_ferr - b_ferr, 0);
        send_byte(8'hA5, 1);
        @(negedge clk);
        $display("after glitch tx=a5 decoded=%02h", ibyte_seen);
        chk("post glitch istb", tot_istb - b_istb, 1);
        chk("post glitch byte", {24'd0, ibyte_seen}, 32'h0000_00A5);

        // Reset mid-byte inside an image.
        send_byte(8'hFF, 1);
        send_byte(8'hD8, 1);
        send_byte(8'h33, 1);
        @(negedge clk);
        chk("pre reset active", {31'd0, jpeg_active}, 32'd1);
        chk("pre reset cnt", {8'd0, recv_byte_cnt}, 32'd3);
        b_last = tot_last; b_emit = tot_emit;
        line_hold(1'b0, BIT_CYC);
        for (int i = 0; i < 4; i++) line_hold(i[0], BIT_CYC);
        uart_rx = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        $display("mid-byte reset: cnt=%0d active=%0b valid=%0b", recv_byte_cnt, jpeg_active, recv_data_vaild);
        chk("mrst data",   {24'd0, recv_data}, 32'd0);
        chk("mrst valid",  {31'd0, recv_data_vaild}, 32'd0);
        chk("mrst cnt",    {8'd0, recv_byte_cnt}, 32'd0);
        chk("mrst active", {31'd0, jpeg_active}, 32'd0);
        line_hold(1'b1, 12 * BIT_CYC);
        chk("mrst no last", tot_last - b_last, 0);
        chk("mrst no emit", tot_emit - b_emit, 0);
        send_byte(8'hFF, 1);
        send_byte(8'hD8, 1);
        @(negedge clk);
        $display("new image after reset: cnt=%0d active=%0b", recv_byte_cnt, jpeg_active);
        chk("new img cnt", {8'd0, recv_byte_cnt}, 32'd2);
        chk("new img active", {31'd0, jpeg_active}, 32'd1);
        chk("new img emits", tot_emit - b_emit, 2);
        send_byte(8'hFF, 1);
        send_byte(8'hD9, 1);
        @(negedge clk);
        $display("new image closed: cnt=%0d active=%0b", recv_byte_cnt, jpeg_active);
        chk("new img eoi last", tot_last - b_last, 1);
        chk("new img eoi cnt", {8'd0, recv_byte_cnt}, 32'd4);
        chk("new img eoi active", {31'd0, jpeg_active}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_jpeg_rx.md
Name: uart_jpeg_rx

Overview:
- Receive-side counterpart of the UART JPEG transmit path: accepts an 8N1 UART stream from the PC and recovers bytes.
- Frames the byte stream into JPEG images: hunts for SOI (FF D8) and forwards every byte through EOI (FF D9) with a last flag.
- Sits between a board RX pin and a downstream JPEG consumer (decoder or loopback checker); its output handshake mirrors the encoder's send_data_* interface.

Parameters:
- CLK_FRE, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, UART bit rate; BIT_CYC = CLK_FRE/BAUD_RATE (434 at defaults), integer division.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- uart_rx  input  1  asynchronous serial input, idle high.
- recv_data  output  8  image byte.
- recv_data_vaild  output  1  one-cycle strobe; recv_data is valid this cycle.
- recv_data_last  output  1  high with the strobe of the EOI D9 byte only.
- recv_byte_cnt  output  24  bytes emitted in the current image, SOI included; saturates at FFFFFF.
- jpeg_active  output  1  high from SOI detect until EOI emitted or abort.
- frame_error  output  1  one-cycle pulse on a bad stop bit.

Behaviour:
- Reset: all outputs 0, RX state IDLE, framer state HUNT, synchronizer flops 1, counters 0. Reset mid-byte or mid-image discards everything; no last is emitted.
- RX synchronizer: 2 flops on uart_rx; all logic uses the second flop (rxs).
- RX state machine: IDLE -> START -> DATA -> STOP.
  - IDLE: rxs 1->0 edge -> START, bit counter cleared.
  - START: wait BIT_CYC/2 cycles, then sample rxs. Low -> DATA. High -> IDLE (glitch, no byte).
  - DATA: sample every BIT_CYC cycles, LSB first, 8 bits -> STOP.
  - STOP: after BIT_CYC cycles sample rxs. High -> internal byte strobe (1 cycle), then IDLE. Low -> frame_error pulse, then WAIT_HIGH.
  - WAIT_HIGH: holds until rxs = 1, then IDLE.
- Framer states: HUNT, HUNT_FF, IMG, IMG_FF; acts only on internal byte strobes.
  - HUNT: FF -> HUNT_FF; any other byte ignored.
  - HUNT_FF: D8 -> IMG, jpeg_active=1, cnt cleared. FF -> stay HUNT_FF. Other -> HUNT.
  - On SOI, emit FF on cycle N+1 and D8 on cycle N+2 (N = D8 strobe cycle); cnt = 2 after D8.
  - IMG: each byte emitted one cycle after its strobe. FF -> IMG_FF.
  - IMG_FF: byte emitted. D9 -> emitted with recv_data_last=1, then HUNT, jpeg_active=0 the cycle after. FF -> stay IMG_FF. Other (incl. D8, 00 stuffing) -> IMG; nested SOI is plain data.
- frame_error while in IMG/IMG_FF aborts the image: -> HUNT, jpeg_active=0 the next cycle, no last, erroneous byte not emitted. In HUNT states it only pulses.
- recv_byte_cnt increments on every emitted strobe and holds its value after EOI/abort until the next SOI.
- Byte strobes are at least 10*BIT_CYC cycles apart, so the two-cycle SOI emission never collides. No back-pressure; the consumer must accept one byte per cycle.

Decomposition:
- Package jpeg_rx_pkg: constants MARKER_FF=8'hFF, SOI_LO=8'hD8, EOI_LO=8'hD9; enums rx_state_t {IDLE,START,DATA,STOP,WAIT_HIGH} and frm_state_t {HUNT,HUNT_FF,IMG,IMG_FF}.
- Sub-module uart_rx_byte holds the synchronizer and RX FSM. Outputs: byte, byte strobe, frame_error. Parameters: CLK_FRE, BAUD_RATE.
- Framer logic lives in uart_jpeg_rx.

Test Plan:
- Defaults; send 0x55 alone -> internal strobe with 0x55 about 9.5 bit times after the start edge; recv_data_vaild stays 0; jpeg_active stays 0.
- Send FF D8 12 34 FF 00 FF D9 -> 8 strobes FF,D8,12,34,FF,00,FF,D9; last only on D9; recv_byte_cnt=8; jpeg_active falls after D9.
- Send 00 FF 41 FF FF D8 AA FF D9 -> output only FF,D8,AA,FF,D9; cnt=5.
- Drive uart_rx low for 100 cycles (< BIT_CYC/2) then high -> no strobe, no frame_error; a following valid byte decodes correctly.
- In image FF D8 11, send 22 with stop bit low -> frame_error pulse, 22 not emitted, jpeg_active=0; subsequent FF D9 produces no output.
- Assert rst for 1 cycle mid-byte inside an image -> all outputs 0; next clean FF D8 starts a new image with cnt=2.
